// File: rtl/int_ctrl_pkg.sv
// Shared constants for the peripheral interrupt controller: register offsets,
// FSM state encoding and STATUS register bit positions.
package int_ctrl_pkg;

    localparam logic [31:0] OFF_PENDING = 32'd0;
    localparam logic [31:0] OFF_MASK    = 32'd4;
    localparam logic [31:0] OFF_EDGE    = 32'd8;
    localparam logic [31:0] OFF_STATUS  = 32'd12;

    localparam int STAT_IN_SERVICE = 31;
    localparam int STAT_ANY_PEND   = 30;
    localparam int STAT_ID_LSB     = 0;
    localparam int STAT_ID_W       = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc_lsb.sv
// Lowest-index-first priority encoder: valid plus the 5-bit index of the
// lowest set request bit.
module prio_enc_lsb #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [4:0]   idx
);

    always_comb begin
        idx = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 5'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/int_ctrl.sv
// Peripheral interrupt controller: pending/mask/edge-select registers, fixed
// priority and the external-interrupt handshake with coprocessor 0.
// Optional two-flop input synchronizer is enabled with IRQ_SYNC_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | o_irq follows |(pending & mask); waiting for i_irq_taken
//   SERVICE | winner latched in o_irq_id; o_irq held low until i_eret
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h00000080
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_data,
    input  logic             i_irq_taken,
    input  logic             i_eret,
    output logic [31:0]      o_data,
    output logic             o_irq,
    output logic [4:0]       o_irq_id,
    output logic             o_in_service
);

    state_t           state;
    logic [N_IRQ-1:0] irq_s, prev, pending, mask, edge_sel;
    logic [N_IRQ-1:0] clr_w1c, clr_take, pend_next;
    logic             win_valid, take;
    logic [4:0]       win_idx;
    logic             sel_pend, sel_mask, sel_edge, sel_stat;
    logic             unused_data;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1, sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = i_irq;
`endif

    assign sel_pend = (i_addr == BASE_ADDR + OFF_PENDING);
    assign sel_mask = (i_addr == BASE_ADDR + OFF_MASK);
    assign sel_edge = (i_addr == BASE_ADDR + OFF_EDGE);
    assign sel_stat = (i_addr == BASE_ADDR + OFF_STATUS);

    assign unused_data = ^i_data;

    prio_enc_lsb #(.N(N_IRQ)) u_prio (
        .req   (pending & mask),
        .valid (win_valid),
        .idx   (win_idx)
    );

    assign take    = (state == IDLE) && i_irq_taken && win_valid;
    assign clr_w1c = (i_we && sel_pend) ? i_data[N_IRQ-1:0] : '0;

    always_comb begin
        clr_take = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_take[i] = take && (win_idx == 5'(i));
        end
    end

    // New edges are OR-ed in after the clears so a same-cycle set wins.
    assign pend_next = (edge_sel & ((pending & ~clr_w1c & ~clr_take) | (irq_s & ~prev)))
                     | (~edge_sel & irq_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev     <= '0;
            pending  <= '0;
            mask     <= '1;
            edge_sel <= '0;
        end else begin
            prev    <= irq_s;
            pending <= pend_next;
            if (i_we && sel_mask) mask <= i_data[N_IRQ-1:0];
            if (i_we && sel_edge) edge_sel <= i_data[N_IRQ-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_irq        <= 1'b0;
            o_irq_id     <= 5'd0;
            o_in_service <= 1'b0;
        end else if (state == IDLE) begin
            if (i_irq_taken && win_valid) begin
                state        <= SERVICE;
                o_irq        <= 1'b0;
                o_irq_id     <= win_idx;
                o_in_service <= 1'b1;
            end else begin
                o_irq <= win_valid;
            end
        end else begin
            o_irq <= 1'b0;
            if (i_eret) begin
                state        <= IDLE;
                o_in_service <= 1'b0;
            end
        end
    end

    always_comb begin
        o_data = '0;
        if (sel_pend) begin
            o_data = 32'(pending);
        end else if (sel_mask) begin
            o_data = 32'(mask);
        end else if (sel_edge) begin
            o_data = 32'(edge_sel);
        end else if (sel_stat) begin
            o_data[STAT_IN_SERVICE]                     = o_in_service;
            o_data[STAT_ANY_PEND]                       = win_valid;
            o_data[STAT_ID_LSB +: STAT_ID_W]            = o_irq_id;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl plus hand-written sequences for
// asynchronous reset and the synchronizer latency.
module tb_int_ctrl;

    localparam logic [31:0] A_P = 32'h80;
    localparam logic [31:0] A_M = 32'h84;
    localparam logic [31:0] A_E = 32'h88;
    localparam logic [31:0] A_S = 32'h8C;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_irq = '0;
    logic        i_we = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        i_irq_taken = 1'b0;
    logic        i_eret = 1'b0;
    logic [31:0] o_data;
    logic        o_irq;
    logic [4:0]  o_irq_id;
    logic        o_in_service;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl #(.N_IRQ(8), .BASE_ADDR(32'h80)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_irq        (i_irq),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_irq_taken  (i_irq_taken),
        .i_eret       (i_eret),
        .o_data       (o_data),
        .o_irq        (o_irq),
        .o_irq_id     (o_irq_id),
        .o_in_service (o_in_service)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  irq;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        tk;
        logic        er;
        logic [31:0] raddr;
        logic [31:0] xdata;
        logic        xirq;
        logic [4:0]  xid;
        logic        xisv;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [7:0] irq, input logic we, input logic [31:0] wa,
                        input logic [31:0] wd, input logic tk, input logic er,
                        input logic [31:0] ra, input logic [31:0] xd, input logic xi,
                        input logic [4:0] xid, input logic xs);
        vec_t v;
        v.irq = irq; v.we = we; v.waddr = wa; v.wdata = wd; v.tk = tk; v.er = er;
        v.raddr = ra; v.xdata = xd; v.xirq = xi; v.xid = xid; v.xisv = xs;
        vt.push_back(v);
    endtask

    task automatic cyc(input logic [7:0] irq, input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic tk, input logic er,
                       input logic [31:0] ra);
        @(negedge i_clk);
        i_irq = irq; i_we = we; i_addr = wa; i_data = wd; i_irq_taken = tk; i_eret = er;
        @(posedge i_clk);
        #1;
        i_we = 1'b0; i_irq_taken = 1'b0; i_eret = 1'b0; i_addr = ra;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

`ifndef IRQ_SYNC_EN
        //    irq    we   waddr data          tk er  raddr  xdata          xirq xid   xisv
        addv(8'h00, 0, A_M, 0,             0, 0, A_M, 32'hFF,         0, 5'd0, 0);
        addv(8'h00, 0, A_E, 0,             0, 0, A_E, 32'h00,         0, 5'd0, 0);
        addv(8'h00, 0, A_S, 0,             0, 0, A_S, 32'h0,          0, 5'd0, 0);
        addv(8'h00, 1, A_E, 32'h04,        0, 0, A_E, 32'h04,         0, 5'd0, 0);
        addv(8'h04, 0, A_P, 0,             0, 0, A_P, 32'h04,         0, 5'd0, 0);
        addv(8'h04, 0, A_S, 0,             0, 0, A_S, 32'h40000000,   1, 5'd0, 0);
        addv(8'h04, 0, A_P, 0,             1, 0, A_P, 32'h0,          0, 5'd2, 1);
        addv(8'h04, 0, A_S, 0,             0, 0, A_S, 32'h80000002,   0, 5'd2, 1);
        addv(8'h04, 0, A_S, 0,             0, 1, A_S, 32'h00000002,   0, 5'd2, 0);
        addv(8'h04, 1, A_E, 32'h26,        0, 0, A_E, 32'h26,         0, 5'd2, 0);
        addv(8'h26, 0, A_P, 0,             0, 0, A_P, 32'h22,         0, 5'd2, 0);
        addv(8'h26, 0, A_S, 0,             0, 0, A_S, 32'h40000002,   1, 5'd2, 0);
        addv(8'h26, 0, A_P, 0,             1, 0, A_P, 32'h20,         0, 5'd1, 1);
        addv(8'h26, 0, A_S, 0,             0, 1, A_S, 32'h40000001,   0, 5'd1, 0);
        addv(8'h26, 0, A_S, 0,             0, 0, A_S, 32'h40000001,   1, 5'd1, 0);
        addv(8'h26, 0, A_P, 0,             1, 0, A_P, 32'h0,          0, 5'd5, 1);
        addv(8'h26, 0, A_P, 0,             0, 1, A_P, 32'h0,          0, 5'd5, 0);
        addv(8'h01, 0, A_P, 0,             0, 0, A_P, 32'h01,         0, 5'd5, 0);
        addv(8'h01, 0, A_P, 0,             0, 0, A_P, 32'h01,         1, 5'd5, 0);
        addv(8'h01, 1, A_P, 32'h01,        0, 0, A_P, 32'h01,         1, 5'd5, 0);
        addv(8'h01, 0, A_P, 0,             1, 0, A_P, 32'h01,         0, 5'd0, 1);
        addv(8'h01, 0, A_S, 0,             0, 0, A_S, 32'hC0000000,   0, 5'd0, 1);
        addv(8'h01, 0, A_S, 0,             0, 1, A_S, 32'h40000000,   0, 5'd0, 0);
        addv(8'h01, 0, A_S, 0,             0, 0, A_S, 32'h40000000,   1, 5'd0, 0);
        addv(8'h01, 1, A_M, 32'hFE,        0, 0, A_M, 32'hFE,         1, 5'd0, 0);
        addv(8'h01, 0, A_S, 0,             0, 0, A_S, 32'h0,          0, 5'd0, 0);
        addv(8'h01, 1, A_M, 32'hFFFFFFFF,  0, 0, A_M, 32'hFF,         0, 5'd0, 0);
        addv(8'h01, 0, A_S, 0,             0, 0, A_S, 32'h40000000,   1, 5'd0, 0);
        addv(8'h01, 1, A_E, 32'h08,        0, 0, A_E, 32'h08,         1, 5'd0, 0);
        addv(8'h09, 1, A_P, 32'h08,        0, 0, A_P, 32'h09,         1, 5'd0, 0);
        addv(8'h09, 1, A_P, 32'h08,        0, 0, A_P, 32'h01,         1, 5'd0, 0);
        addv(8'h01, 0, A_P, 0,             1, 0, A_P, 32'h01,         0, 5'd0, 1);
        addv(8'h01, 0, A_S, 0,             1, 1, A_S, 32'h40000000,   0, 5'd0, 0);
        addv(8'h01, 0, A_S, 0,             0, 1, A_S, 32'h40000000,   1, 5'd0, 0);
        addv(8'h01, 0, 32'h90, 0,          0, 0, 32'h90, 32'h0,       1, 5'd0, 0);
        addv(8'h01, 0, 32'h7C, 0,          0, 0, 32'h7C, 32'h0,       1, 5'd0, 0);
        addv(8'h00, 0, A_P, 0,             0, 0, A_P, 32'h0,          1, 5'd0, 0);
        addv(8'h00, 0, A_S, 0,             1, 0, A_S, 32'h0,          0, 5'd0, 0);

        foreach (vt[k]) begin
            cyc(vt[k].irq, vt[k].we, vt[k].waddr, vt[k].wdata, vt[k].tk, vt[k].er, vt[k].raddr);
            chk($sformatf("v%0d data", k), o_data, vt[k].xdata);
            chk($sformatf("v%0d irq", k), 32'(o_irq), 32'(vt[k].xirq));
            chk($sformatf("v%0d id", k), 32'(o_irq_id), 32'(vt[k].xid));
            chk($sformatf("v%0d in_service", k), 32'(o_in_service), 32'(vt[k].xisv));
        end

        // Asynchronous reset in the middle of SERVICE with MASK not at reset value.
        cyc(8'h01, 1, A_M, 32'h7F, 0, 0, A_M);
        chk("rst pre mask", o_data, 32'h7F);
        cyc(8'h01, 0, A_M, 0, 0, 0, A_M);
        chk("rst pre irq", 32'(o_irq), 32'd1);
        cyc(8'h01, 0, A_M, 0, 1, 0, A_M);
        chk("rst pre in_service", 32'(o_in_service), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst irq", 32'(o_irq), 32'd0);
        chk("rst in_service", 32'(o_in_service), 32'd0);
        chk("rst id", 32'(o_irq_id), 32'd0);
        chk("rst mask", o_data, 32'hFF);
        i_addr = A_P;
        #1;
        chk("rst pending", o_data, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
`else
        // Synchronizer latency: pending on edge 3, o_irq on edge 4.
        cyc(8'h00, 1, A_E, 32'h10, 0, 0, A_E);
        chk("sync edge_sel", o_data, 32'h10);
        @(negedge i_clk);
        i_irq = 8'h10;
        i_addr = A_P;
        for (int e = 1; e <= 4; e++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("sync e%0d pending", e), o_data, (e >= 3) ? 32'h10 : 32'h0);
            chk($sformatf("sync e%0d irq", e), 32'(o_irq), (e >= 4) ? 32'd1 : 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Peripheral interrupt controller and the request side of the CPU external-interrupt interface.
- Collects N_IRQ peripheral request lines, latches them as pending, and applies a mask and fixed priority.
- Drives the single external-interrupt line into the coprocessor 0 block and tracks the in-service source until the CPU executes eret.
- The CPU reads and writes its registers with the same we/addr/data memory-map style used by coprocessor 0.

Parameters:
N_IRQ, 8, number of request lines (1..32)
BASE_ADDR, 32'h00000080, byte address of register 0; registers sit at BASE_ADDR+0/4/8/C

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_irq  in  N_IRQ  peripheral request lines, asynchronous to i_clk
i_we  in  1  register write enable
i_addr  in  32  register byte address
i_data  in  32  write data
i_irq_taken  in  1  one-cycle pulse from coprocessor 0 meaning the interrupt was accepted and EPC written
i_eret  in  1  eret instruction executing
o_data  out  32  read data, combinational from i_addr
o_irq  out  1  external interrupt request to coprocessor 0, registered
o_irq_id  out  5  index of the source in service
o_in_service  out  1  a source is in service

Behaviour:
- Register map:
  - +0 PENDING: read; write 1 to clear, edge sources only.
  - +4 MASK: read/write; 1 = enabled; reset value is all ones.
  - +8 EDGE_SEL: read/write; 1 = rising-edge source, 0 = level source; reset value 0.
  - +C STATUS: read only; bit31 = in_service, bit30 = any pending&mask, [4:0] = in-service id.
  - Any other address reads 0. Bits at or above N_IRQ read 0 and ignore writes.
- Input sampling:
  - A prev register holds the sampled input.
  - Edge source: pending bit is set when sampled input is 1 and prev is 0. It is sticky until W1C.
  - Level source: pending bit is the sampled level every cycle. W1C has no effect.
- Set/clear collision: a new edge and a W1C on the same bit in the same cycle leaves the bit set (set wins).
- Priority: the lowest index among pending&MASK wins. The winner is computed combinationally.
- State machine (2 states):
  - IDLE: o_irq <= |(pending&MASK) on each clock. On i_irq_taken: latch winner into id, clear that bit's pending if it is an edge source, go to SERVICE, and o_irq <= 0 on the same edge.
  - SERVICE: o_irq held 0; o_in_service = 1. On i_eret go to IDLE; o_irq may reassert on the following edge.
  - i_irq_taken while in SERVICE is ignored.
  - i_eret while in IDLE is ignored.
- i_irq_taken and i_eret in the same cycle in SERVICE: eret wins; go to IDLE.
- i_irq_taken when the winner is none: stay IDLE.
- MASK cleared while o_irq = 1 in IDLE: o_irq drops on the next edge.
- Reset, asynchronous at any time including mid-service:
  - pending, prev and sync flops = 0; MASK = all ones; EDGE_SEL = 0.
  - state = IDLE; o_irq = 0; o_irq_id = 0; o_in_service = 0.

Optional Feature:
- IRQ_SYNC_EN defined:
  - Each i_irq bit passes through a two-flop synchronizer (reset 0) before prev/edge logic.
  - A rising input becomes pending on the 3rd rising clock edge after it is stable.
  - o_irq asserts 1 edge later.
- IRQ_SYNC_EN undefined:
  - i_irq feeds the edge/level logic directly, for synchronous sources.
  - Pending is set on the 1st edge; o_irq asserts on the 2nd edge.

Decomposition:
- Package int_ctrl_pkg holds:
  - register offset constants OFF_PENDING=0, OFF_MASK=4, OFF_EDGE=8, OFF_STATUS=12;
  - state enum IDLE/SERVICE;
  - STATUS bit positions.
- Sub-module prio_enc_lsb (N_IRQ-wide lowest-index-first priority encoder, outputs valid + 5-bit index). It is reused by the STATUS read path.

Test Plan (build without IRQ_SYNC_EN unless noted):
- Reset, then EDGE_SEL=8'h04 and a 0->1 step on i_irq[2] -> PENDING reads 32'h4 on edge 1; o_irq=1 on edge 2.
- i_irq[5] and i_irq[1] both rising, both edge sources; pulse i_irq_taken -> o_irq_id=1, o_in_service=1, PENDING=32'h20, o_irq=0. Then pulse i_eret -> o_irq=1 on the next edge; the next take gives id 5.
- Level source i_irq[0] held high through take and eret -> o_irq reasserts after eret. A W1C of 32'h1 does not clear PENDING[0].
- MASK=8'hFE with i_irq[0] high, level -> o_irq stays 0; STATUS bit30=0. Writing MASK=8'hFF -> o_irq=1 next edge.
- Edge on i_irq[3] in the same cycle as a W1C of 32'h8 -> PENDING[3]=1. Same-cycle i_irq_taken+i_eret in SERVICE -> state IDLE.
- Assert i_rst_n=0 mid-SERVICE, asynchronously -> o_irq=0, o_in_service=0 and MASK reads 32'hFF immediately. With IRQ_SYNC_EN, a step on i_irq[4] -> pending on edge 3 and o_irq on edge 4.
